// File: rtl/riscv_base_divider.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring divider on operand magnitudes, with sign fix-up on completion.
//
//   state | meaning
//   IDLE  | no operation; outputs hold the last result
//   BUSY  | one restoring step per unheld edge, counter counts 32 -> 0
//   DONE  | one-cycle writeback strobe; may accept the next divide
module riscv_base_divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o,
  output logic [4:0]  writeback_rd_idx_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        rem_sel_q, rem_sel_d;
  logic        b_zero_q, b_zero_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic        is_div, is_signed, is_rem, start;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh;
  logic [31:0] quo_sh, rem_step, quo_step, result;
  logic        step_ge;
  logic        unused_opcode_bits;

  // funct3 = 1xx selects the divide group; bit 12 = unsigned, bit 13 = remainder
  assign is_div    = (opcode_opcode_i[6:0] == 7'b0110011) &&
                     (opcode_opcode_i[31:25] == 7'b0000001) && opcode_opcode_i[14];
  assign is_signed = ~opcode_opcode_i[12];
  assign is_rem    = opcode_opcode_i[13];
  assign start     = opcode_valid_i && is_div && !opcode_invalid_i;

  assign unused_opcode_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

  assign a_mag = (is_signed && opcode_ra_operand_i[31]) ? -opcode_ra_operand_i : opcode_ra_operand_i;
  assign b_mag = (is_signed && opcode_rb_operand_i[31]) ? -opcode_rb_operand_i : opcode_rb_operand_i;

  // The partial remainder is always below the divisor, so when the trial
  // subtraction succeeds the low 32 bits of the difference are exact.
  assign rem_sh   = {rem_q, quo_q[31]};
  assign quo_sh   = {quo_q[30:0], 1'b0};
  assign step_ge  = rem_sh >= {1'b0, div_q};
  assign rem_step = step_ge ? (rem_sh[31:0] - div_q) : rem_sh[31:0];
  assign quo_step = step_ge ? (quo_sh | 32'd1) : quo_sh;

  always_comb begin
    result = quo_step;
    if (rem_sel_q) begin
      result = neg_rem_q ? -rem_step : rem_step;
    end else if (neg_quo_q && !b_zero_q) begin
      result = -quo_step;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    b_zero_d  = b_zero_q;
    rd_d      = rd_q;
    wb_val_d  = wb_val_q;
    wb_rd_d   = wb_rd_q;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else if (!hold_i) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            state_d   = ST_BUSY;
            cnt_d     = 6'd32;
            rem_d     = 32'd0;
            quo_d     = a_mag;
            div_d     = b_mag;
            neg_quo_d = is_signed && (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]);
            neg_rem_d = is_signed && opcode_ra_operand_i[31];
            rem_sel_d = is_rem;
            b_zero_d  = (opcode_rb_operand_i == 32'd0);
            rd_d      = opcode_rd_idx_i;
          end
        end
        ST_BUSY: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d  = ST_DONE;
            wb_val_d = result;
            wb_rd_d  = rd_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      div_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      b_zero_q  <= 1'b0;
      rd_q      <= 5'd0;
      wb_val_q  <= 32'd0;
      wb_rd_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      b_zero_q  <= b_zero_d;
      rd_q      <= rd_d;
      wb_val_q  <= wb_val_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign busy_o             = (state_q == ST_BUSY);
  assign writeback_valid_o  = (state_q == ST_DONE);
  assign writeback_value_o  = wb_val_q;
  assign writeback_rd_idx_o = wb_rd_q;

endmodule
